rng_note_gen: RTL and testbench
===============================

RNG_NOTE_GEN -- requirements
Module: rng_note_gen

Parameters (one per line: name, default, meaning)
- WIDTH, 16, LFSR width (>= 8).
- NOTE_W, 6, note width (<= WIDTH-2).
- NOTE_MAX, 47, highest legal note; 2^(NOTE_W-1)-1 <= NOTE_MAX <= 2^NOTE_W-1 and NOTE_MAX >= 8.
- RESET_SEED, 16'hA455, LFSR reset/recovery value; never all-ones.
- NOTE_INIT, 6'd45, note reset value; must be <= NOTE_MAX.

Interface
REQ-001 clk  in  1  single clock, all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 en  in  1  note-stepping enable.
REQ-004 pulse  in  1  note step request, sampled each cycle.
REQ-005 mode  in  2  00 random, 01 walk, 10 hold, 11 treated as random.
REQ-006 seed_load  in  1  load seed into LFSR.
REQ-007 seed  in  WIDTH  seed value.
REQ-008 taps  in  WIDTH  feedback tap mask.
REQ-009 out  out  WIDTH  LFSR state.
REQ-010 note  out  NOTE_W  current note, always <= NOTE_MAX.
REQ-011 note_valid  out  1  one-cycle strobe after each accepted step.
REQ-012 lockup  out  1  one-cycle flag on lock-up recovery.

Function
REQ-013 LFSR free-runs every cycle: out <= {out[WIDTH-2:0], fb}, fb = XNOR-reduction of (out & taps).
REQ-014 Lock-up: if out is all-ones, the next out SHALL be RESET_SEED and lockup SHALL be 1 for that cycle.
REQ-015 seed_load has priority over shifting: out <= seed; an all-ones seed loads RESET_SEED instead and sets lockup for one cycle.
REQ-016 lockup SHALL be 0 in every cycle not covered by REQ-014/015.
REQ-017 Step accepted on any edge where pulse & en = 1; pulse held high steps every cycle.
REQ-018 Step uses out as registered before that edge, even if seed_load is simultaneously high.
REQ-019 Random mode: cand = out[NOTE_W-1:0]; if cand > NOTE_MAX then note <= cand - (NOTE_MAX+1), else note <= cand.
REQ-020 Walk mode: step = out[1:0] + 1 (range 1..4); direction up if out[WIDTH-1] = 1, otherwise down.
REQ-021 Walk up: note <= note + step if <= NOTE_MAX, else reflect to note - step.
REQ-022 Walk down: note <= note - step if note >= step, else reflect to note + step.
REQ-023 Walk arithmetic SHALL use NOTE_W+1 bits internally; no wrap-around permitted.
REQ-024 Hold mode: note unchanged; step still accepted.
REQ-025 note_valid SHALL be 1 in the cycle after each accepted step in every mode, 0 otherwise.
REQ-026 Latency: note updates at the accepting edge and is visible in the same cycle as note_valid.
REQ-027 No step accepted (pulse = 0 or en = 0): note holds.
REQ-028 mode change takes effect on the next accepted step; no stored mode state.

Reset
REQ-029 rst = 1 at an edge: out = RESET_SEED, note = NOTE_INIT, note_valid = 0, lockup = 0.
REQ-030 rst dominates seed_load, pulse and lock-up recovery.
REQ-031 rst applied mid-walk abandons the step; no partial update.

Verification
REQ-032 Reset, taps = 16'hB400, no load: out 16'hA455 -> 16'h48AA after one edge.
REQ-033 Reset, mode = 00, pulse & en one cycle at first edge: note = 21 (6'h15), note_valid = 1 for exactly one cycle.
REQ-034 Reset, mode = 01, pulse & en at first edge: up, step 2, note 45 -> 47. Force note = 47 with up step 2: note -> 45 (reflect).
REQ-035 seed_load with seed = 16'hFFFF: out = 16'hA455 and lockup = 1 for one cycle. Simultaneous pulse in mode 00 uses the pre-load out.
REQ-036 Random mode with out[5:0] = 6'd60: note = 12. Sweep all 64 values: note always <= 47.
REQ-037 rst asserted while pulse held high in mode 01: outputs match REQ-029 at that edge. Stepping resumes on the first non-reset edge.

Source files
------------

// File: rtl/rng_note_gen.sv
// Free-running XNOR LFSR with lock-up recovery, driving a note generator
// that picks random notes, random-walks with reflection, or holds.
module rng_note_gen #(
    parameter int                 WIDTH      = 16,
    parameter int                 NOTE_W     = 6,
    parameter int                 NOTE_MAX   = 47,
    parameter logic [WIDTH-1:0]   RESET_SEED = 16'hA455,
    parameter logic [NOTE_W-1:0]  NOTE_INIT  = 6'd45
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pulse,
    input  logic [1:0]        mode,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic [WIDTH-1:0]  taps,
    output logic [WIDTH-1:0]  out,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              lockup
);

    localparam logic [NOTE_W:0] NOTE_MAX_W  = (NOTE_W+1)'(NOTE_MAX);
    localparam logic [NOTE_W:0] NOTE_SPAN_W = (NOTE_W+1)'(NOTE_MAX + 1);
    localparam logic [NOTE_W:0] ONE_W       = (NOTE_W+1)'(1);

    logic [WIDTH-1:0]  out_q, out_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              valid_q, valid_d;
    logic              lock_q, lock_d;

    logic              fb;
    logic              step_acc;
    logic [NOTE_W:0]   cand_w, rand_w, step_w, note_w, up_w, dn_w, walk_w;

    // LFSR next state: a load beats shifting, and all-ones never survives.
    always_comb begin
        fb     = ~^(out_q & taps);
        out_d  = {out_q[WIDTH-2:0], fb};
        lock_d = 1'b0;
        if (seed_load) begin
            if (&seed) begin
                out_d  = RESET_SEED;
                lock_d = 1'b1;
            end else begin
                out_d = seed;
            end
        end else if (&out_q) begin
            out_d  = RESET_SEED;
            lock_d = 1'b1;
        end
    end

    // Note arithmetic is one bit wider than the note so nothing wraps.
    always_comb begin
        cand_w = {1'b0, out_q[NOTE_W-1:0]};
        rand_w = (cand_w > NOTE_MAX_W) ? (cand_w - NOTE_SPAN_W) : cand_w;

        step_w = {{(NOTE_W-1){1'b0}}, out_q[1:0]} + ONE_W;
        note_w = {1'b0, note_q};
        up_w   = note_w + step_w;
        dn_w   = note_w - step_w;
        if (out_q[WIDTH-1]) begin
            walk_w = (up_w <= NOTE_MAX_W) ? up_w : dn_w;
        end else begin
            walk_w = (note_w >= step_w) ? dn_w : up_w;
        end

        step_acc = pulse & en;
        valid_d  = step_acc;
        note_d   = note_q;
        if (step_acc) begin
            case (mode)
                2'b01:   note_d = walk_w[NOTE_W-1:0];
                2'b10:   note_d = note_q;
                default: note_d = rand_w[NOTE_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= RESET_SEED;
            note_q  <= NOTE_INIT;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
        end
    end

    assign out        = out_q;
    assign note       = note_q;
    assign note_valid = valid_q;
    assign lockup     = lock_q;

endmodule

// File: tb/tb_rng_note_gen.sv
// Bench for rng_note_gen: a behavioural model predicts LFSR/lock-up each cycle
// and queues the expected note for every accepted step.
module tb_rng_note_gen;

    localparam int NOTE_MAX = 47;

    logic        clk;
    logic        rst;
    logic        en;
    logic        pulse;
    logic [1:0]  mode;
    logic        seed_load;
    logic [15:0] seed;
    logic [15:0] taps;
    logic [15:0] out;
    logic [5:0]  note;
    logic        note_valid;
    logic        lockup;

    rng_note_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pulse      (pulse),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .taps       (taps),
        .out        (out),
        .note       (note),
        .note_valid (note_valid),
        .lockup     (lockup)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0]  exp_q[$];
    logic [15:0] m_out;
    int          m_note;
    logic        m_valid;
    logic        m_lock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic drive(input logic r, input logic e, input logic p, input logic [1:0] md,
                         input logic sl, input logic [15:0] sd);
        logic        fbit;
        int          st;
        int          c;
        rst = r; en = e; pulse = p; mode = md; seed_load = sl; seed = sd;
        if (r) begin
            m_out = 16'hA455; m_note = 45; m_valid = 1'b0; m_lock = 1'b0;
        end else begin
            if (e && p) begin
                if (md == 2'b01) begin
                    st = int'(m_out[1:0]) + 1;
                    if (m_out[15]) m_note = (m_note + st <= NOTE_MAX) ? m_note + st : m_note - st;
                    else           m_note = (m_note >= st) ? m_note - st : m_note + st;
                end else if (md != 2'b10) begin
                    c = int'(m_out[5:0]);
                    m_note = (c > NOTE_MAX) ? c - (NOTE_MAX + 1) : c;
                end
                exp_q.push_back(6'(m_note));
            end
            m_valid = e && p;
            fbit = ~^(m_out & taps);
            m_lock = 1'b0;
            if (sl) begin
                if (sd == 16'hFFFF) begin m_out = 16'hA455; m_lock = 1'b1; end
                else m_out = sd;
            end else if (m_out == 16'hFFFF) begin
                m_out = 16'hA455; m_lock = 1'b1;
            end else begin
                m_out = {m_out[14:0], fbit};
            end
        end
        @(posedge clk);
        #1;
        chk("out", out, m_out);
        chk("lockup", lockup, m_lock);
        chk("note_valid", note_valid, m_valid);
        chk("note_range", (note <= 6'(NOTE_MAX)), 1);
        if (note_valid) begin
            if (exp_q.size() == 0) chk("note_unexpected", 1, 0);
            else chk("note", note, exp_q.pop_front());
        end else begin
            chk("note_hold", note, m_note);
        end
    endtask

    initial begin
        logic [9:0] hi;
        rst = 1'b1; en = 1'b0; pulse = 1'b0; mode = 2'b00;
        seed_load = 1'b0; seed = 16'h0; taps = 16'hB400;
        m_out = 16'hA455; m_note = 45; m_valid = 1'b0; m_lock = 1'b0;

        // reset and first shift
        drive(1, 0, 0, 2'b00, 0, 0);
        chk("rst_out", out, 16'hA455);
        chk("rst_note", note, 45);
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("first_shift", out, 16'h48AA);

        // random-mode first step
        drive(1, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b00, 0, 0);
        chk("rand_first", note, 21);
        drive(0, 0, 0, 2'b00, 0, 0);

        // walk up, then reflect at the top
        drive(1, 0, 0, 2'b01, 0, 0);
        drive(0, 1, 1, 2'b01, 0, 0);
        chk("walk_up", note, 47);
        drive(0, 0, 0, 2'b01, 1, 16'h8001);
        drive(0, 1, 1, 2'b01, 0, 0);
        chk("walk_reflect", note, 45);

        // all-ones load with simultaneous step on the pre-load value
        drive(1, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b00, 1, 16'hFFFF);
        chk("load_ones_out", out, 16'hA455);
        chk("load_ones_lock", lockup, 1);
        chk("preload_note", note, 21);
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("lock_clear", lockup, 0);

        // natural lock-up: zero taps shift ones in
        taps = 16'h0000;
        drive(0, 0, 0, 2'b00, 1, 16'h7FFF);
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("reach_ones", out, 16'hFFFF);
        drive(0, 0, 0, 2'b00, 0, 0);
        chk("recover_lock", lockup, 1);
        taps = 16'hB400;

        // random-mode sweep of all 64 candidates
        drive(0, 0, 0, 2'b00, 1, 16'h0000);
        for (int v = 1; v <= 64; v++) begin
            hi = 10'($urandom_range(0, 511));
            drive(0, 1, 1, 2'b00, (v < 64), {hi, 6'(v)});
            if (v == 61) chk("rand_60", note, 12);
        end

        // reset during held walk pulses, then resume
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 2'b01, 0, 0);
        drive(1, 1, 1, 2'b01, 0, 0);
        chk("mid_rst_note", note, 45);
        chk("mid_rst_valid", note_valid, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 2'b01, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) taps = 16'($urandom);
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
